// File: rtl/yuv422_fifo_packer.sv
// yuv422_fifo_packer: YUV444 pixel stream to YUYV FIFO words with 4:2:2 chroma averaging,
// frame tagging, geometry checks and whole-frame drop on FIFO backpressure.
module yuv422_fifo_packer #(
    parameter int BITS     = 8,
    parameter int WIDTH    = 1280,
    parameter int HEIGHT   = 960,
    parameter int CNT_BITS = 16
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic                in_href,
    input  logic                in_vsync,
    input  logic [BITS-1:0]     in_y,
    input  logic [BITS-1:0]     in_u,
    input  logic [BITS-1:0]     in_v,
    input  logic                fifo_full,
    output logic                fifo_wr,
    output logic [2*BITS+1:0]   fifo_wdata,
    output logic                frame_done,
    output logic                frame_dropped,
    output logic                size_err,
    output logic [CNT_BITS-1:0] line_cnt,
    output logic [CNT_BITS-1:0] drop_cnt
);
    typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE, DROP} state_t;
    state_t state, state_nx;

    logic                href_d, vsync_d, vsync_q, href_q;
    logic [BITS-1:0]     y_d, u_d, v_d, y0, u0, v0;
    logic [BITS-1:0]     b_luma, b_chroma;
    logic                b_eol, pend_b, phase, sof_arm, end_req;
    logic [CNT_BITS-1:0] pix_cnt, line_cnt_nx;
    logic                href_act, vs_rise, vs_fall, line_end, in_frame, start;
    logic                due_a, due_f, due_b, due, take_a, fin, size_err_nx;
    logic [BITS:0]       u_sum, v_sum;
    logic [2*BITS+1:0]   wdata_nx;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       state_nx = vs_rise ? WAIT_FRAME : IDLE;
            WAIT_FRAME: state_nx = vs_fall ? ACTIVE : WAIT_FRAME;
            ACTIVE:     state_nx = (due && fifo_full) ? DROP : fin ? WAIT_FRAME : ACTIVE;
            DROP:       state_nx = fin ? WAIT_FRAME : DROP;
            default:    state_nx = IDLE;
        endcase
    end

    // href during vsync blanking is not pixel data
    always_comb begin
        href_act    = href_d & ~vsync_d;
        vs_rise     = vsync_d & ~vsync_q;
        vs_fall     = ~vsync_d & vsync_q;
        line_end    = href_q & ~href_act;
        in_frame    = (state == ACTIVE) || (state == DROP);
        start       = (state == WAIT_FRAME) && vs_fall;
        due_a       = (state == ACTIVE) && href_act && phase;
        due_f       = (state == ACTIVE) && line_end && phase;
        due_b       = (state == ACTIVE) && pend_b;
        due         = due_a | due_f | due_b;
        take_a      = (due_a | due_f) & ~fifo_full;
        fin         = in_frame && (vs_rise || end_req) && !due;
        u_sum       = {1'b0, u0} + {1'b0, u_d} + (BITS+1)'(1);
        v_sum       = {1'b0, v0} + {1'b0, v_d} + (BITS+1)'(1);
        line_cnt_nx = line_cnt + {{(CNT_BITS-1){1'b0}}, line_end & ~&line_cnt};
        size_err_nx = size_err | (line_end && pix_cnt != CNT_BITS'(WIDTH))
                               | (fin && line_cnt_nx != CNT_BITS'(HEIGHT));
        wdata_nx    = due_b ? {1'b0, b_eol | line_end, b_chroma, b_luma}
                            : {sof_arm, 1'b0, due_a ? u_sum[BITS:1] : u0, y0};
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            href_d <= 1'b0; vsync_d <= 1'b0; vsync_q <= 1'b0; href_q <= 1'b0;
            y_d <= '0; u_d <= '0; v_d <= '0; y0 <= '0; u0 <= '0; v0 <= '0;
            b_luma <= '0; b_chroma <= '0; b_eol <= 1'b0; pend_b <= 1'b0;
            phase <= 1'b0; sof_arm <= 1'b0; end_req <= 1'b0; pix_cnt <= '0;
            fifo_wr <= 1'b0; fifo_wdata <= '0; frame_done <= 1'b0; frame_dropped <= 1'b0;
            size_err <= 1'b0; line_cnt <= '0; drop_cnt <= '0;
        end else begin
            href_d        <= in_href;
            vsync_d       <= in_vsync;
            y_d           <= in_y;
            u_d           <= in_u;
            v_d           <= in_v;
            vsync_q       <= vsync_d;
            href_q        <= href_act;
            fifo_wr       <= due & ~fifo_full;
            frame_done    <= fin && state == ACTIVE;
            frame_dropped <= fin && state == DROP;
            pend_b        <= take_a;
            if (due && !fifo_full) fifo_wdata <= wdata_nx;
            if (fin && state == DROP && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
            if (take_a) begin
                b_luma   <= due_a ? y_d : y0;
                b_chroma <= due_a ? v_sum[BITS:1] : v0;
                b_eol    <= due_f;
                sof_arm  <= 1'b0;
            end
            if (href_act && !phase) begin
                y0 <= y_d;
                u0 <= u_d;
                v0 <= v_d;
            end
            if (start) begin
                line_cnt <= '0;
                size_err <= 1'b0;
                sof_arm  <= 1'b1;
                end_req  <= 1'b0;
                pix_cnt  <= '0;
                phase    <= 1'b0;
            end else if (in_frame) begin
                if (href_act) begin
                    pix_cnt <= pix_cnt + {{(CNT_BITS-1){1'b0}}, ~&pix_cnt};
                    phase   <= ~phase;
                end
                if (line_end) begin
                    pix_cnt <= '0;
                    phase   <= 1'b0;
                end
                line_cnt <= line_cnt_nx;
                size_err <= size_err_nx;
                end_req  <= (end_req | vs_rise) & ~fin;
            end
        end
    end
endmodule

// File: doc/yuv422_fifo_packer.md
Name: yuv422_fifo_packer

Overview:
Downstream neighbour of the ISP pipeline. It takes the ISP's per-pixel YUV444 output (href/vsync framed), decimates chroma to 4:2:2 by pair averaging, and packs YUYV-ordered words into the RGB/video FIFO write port. It tags frame start and line end, checks frame geometry, and drops a whole frame cleanly on FIFO backpressure so the downstream video DAC never sees a torn frame.

Parameters:
BITS, 8, pixel component width
WIDTH, 1280, expected active pixels per line (even)
HEIGHT, 960, expected active lines per frame
CNT_BITS, 16, width of line/pixel/statistics counters

Ports:
pclk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
in_href  in  1  line valid; one pixel per pclk while high
in_vsync  in  1  frame sync, active-high blanking pulse
in_y  in  BITS  luma
in_u  in  BITS  Cb
in_v  in  BITS  Cr
fifo_full  in  1  FIFO cannot accept a write this cycle
fifo_wr  out  1  write strobe
fifo_wdata  out  2*BITS+2  {sof, eol, chroma[BITS-1:0], luma[BITS-1:0]}
frame_done  out  1  one-cycle pulse at frame end (written frame only)
frame_dropped  out  1  one-cycle pulse at frame end when frame was dropped
size_err  out  1  sticky per frame; valid with frame_done/frame_dropped
line_cnt  out  CNT_BITS  lines completed in current frame
drop_cnt  out  CNT_BITS  frames dropped since reset, saturating

Behaviour:
- Reset rst_n, asynchronous, active-low; clock pclk. All outputs 0 in reset; state IDLE; counters and pair registers cleared.
- Inputs registered once (href_d, vsync_d); edges detected against the registered copies.
- States: IDLE, WAIT_FRAME, ACTIVE, DROP.
  - IDLE: wait for vsync_d rising edge -> WAIT_FRAME (a frame in progress at reset release is ignored).
  - WAIT_FRAME: on vsync_d falling edge -> ACTIVE; clear line_cnt, size_err; arm sof.
  - ACTIVE: pack pixels; on vsync_d rising edge -> pulse frame_done, check line_cnt==HEIGHT, -> WAIT_FRAME.
  - DROP: suppress all writes; on vsync_d rising edge -> pulse frame_dropped, drop_cnt+1 (saturate at all-ones), -> WAIT_FRAME.
- href high while vsync high is ignored (no writes, no counting).
- Packing: pixel index p counts from 0 per line. Even p: hold Y0,U0,V0. Odd p: cycle after the sample write word A = {Uavg, Y0}; next cycle write word B = {Vavg, Y1}. Uavg=(U0+U1+1)>>1, Vavg likewise, computed at BITS+1 then truncated; no overflow possible.
- Latency: word A write is 2 pclk after the odd pixel is on the input pins; word B 3 pclk. Sustained rate 1 word/pclk, no stall.
- sof=1 only on word A of the first pair of the frame; eol=1 only on word B of the pair closing each line.
- Line end (href_d falling edge): line_cnt+1; if p!=WIDTH set size_err. Odd line length: the unpaired pixel is flushed as A={U0,Y0}, B={V0,Y0} with eol=1; size_err set.
- line_cnt saturates at all-ones; p saturates, no wrap.
- Backpressure: if fifo_full is high in a cycle where a write is due, that write is not issued, fifo_wr stays 0, state -> DROP immediately (rest of frame discarded; already-written words stand). fifo_full with no write due is ignored.
- Simultaneous vsync_d rising edge and pending word B: word B is issued first; the frame-end pulse follows one cycle later.
- fifo_wdata holds last value when fifo_wr=0.
- Reset mid-frame: everything aborts with no pulses; re-sync via IDLE.

Test Plan:
- WIDTH=4,HEIGHT=2, Y=10,20,30,40 U=100,102,... V=200,204,..., fifo_full=0 -> 8 writes: first {sof=1,eol=0,U=101,Y=10}, {V=202,Y=20}; line-end word eol=1; frame_done=1 once, size_err=0, line_cnt=2.
- Same frame, fifo_full asserted on 3rd write -> exactly 2 writes, frame_dropped pulse, drop_cnt=1, no frame_done; next clean frame writes all 8 with sof on first.
- Line of 3 pixels (Y=1,2,3) -> 4 writes, last pair {U3,Y3},{V3,Y3} with eol=1; size_err=1 at frame end.
- 3 lines with HEIGHT=2 -> frame_done with size_err=1, line_cnt=3.
- Reset released mid-line -> no writes until vsync high then low; following frame fully correct.
- U0=U1=255 -> Uavg=255 (no wrap); U0=0,U1=1 -> Uavg=1 (round-half-up).
